// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable latency,
// word-addressed backing array DMem with byte/half/word access and error flag.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic            clock,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [31:0] DMem [DEPTH];

  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        lane;
  logic [IDX_W-1:0]  mem_idx;
  logic              range_err, align_err, funct_err, acc_err;
  logic [31:0]       mem_word, load_data, store_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              mem_we;

  assign word_idx = addr_q[ADDR_W-1:2];
  assign lane     = addr_q[1:0];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign mem_word = DMem[mem_idx];

  assign range_err = (word_idx >= (ADDR_W-2)'(DEPTH));
  assign funct_err = write_q ? (funct3_q > 3'd2)
                             : ((funct3_q == 3'd3) || (funct3_q[2:1] == 2'b11));
  assign align_err = ((funct3_q[1:0] == 2'b01) && lane[0]) ||
                     ((funct3_q[1:0] == 2'b10) && (lane != 2'b00));
  assign acc_err   = range_err || align_err || funct_err;
  assign mem_we    = (state_q == COMMIT) && write_q && !acc_err;

  always_comb begin
    byte_sel = '0;
    case (lane)
      2'd0: byte_sel = mem_word[7:0];
      2'd1: byte_sel = mem_word[15:8];
      2'd2: byte_sel = mem_word[23:16];
      2'd3: byte_sel = mem_word[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

    load_data = '0;
    case (funct3_q)
      3'd0: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1: load_data = {{16{half_sel[15]}}, half_sel};
      3'd2: load_data = mem_word;
      3'd4: load_data = {24'h0, byte_sel};
      3'd5: load_data = {16'h0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Merge store data into the current word so unselected bytes survive.
  always_comb begin
    store_word = mem_word;
    case (funct3_q[1:0])
      2'd0: begin
        case (lane)
          2'd0: store_word[7:0]   = wdata_q[7:0];
          2'd1: store_word[15:8]  = wdata_q[7:0];
          2'd2: store_word[23:16] = wdata_q[7:0];
          2'd3: store_word[31:24] = wdata_q[7:0];
          default: store_word = mem_word;
        endcase
      end
      2'd1: begin
        if (lane[1]) store_word[31:16] = wdata_q[15:0];
        else         store_word[15:0]  = wdata_q[15:0];
      end
      2'd2: store_word = wdata_q;
      default: store_word = mem_word;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          cnt_d    = CNT_W'(LATENCY);
          state_d  = WAIT;
        end
      end
      // WAIT counts down to zero inclusive (LATENCY+1 cycles, also for
      // LATENCY=0) so resp_valid rises LATENCY+2 edges after acceptance.
      WAIT: begin
        if (cnt_q == '0) state_d = COMMIT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      COMMIT: begin
        resp_rdata_d = (write_q || acc_err) ? '0 : load_data;
        resp_err_d   = acc_err;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage is never reset; a reset during WAIT leaves state_q out of COMMIT.
  always_ff @(posedge clock) begin
    if (mem_we) DMem[mem_idx] <= store_word;
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed plan steps plus random
// loads/stores against an arithmetic reference memory.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT0  = 2;
  localparam int LAT1  = 0;

  logic        clock;
  logic        reset;
  logic        sel;
  logic        t_req_valid, t_req_write, t_resp_ready;
  logic [2:0]  t_f3;
  logic [31:0] t_addr, t_wdata;
  logic        o_req_ready, o_resp_valid, o_resp_err;
  logic [31:0] o_resp_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned rmem [2][DEPTH];

  dmem_responder_if #(.ADDR_W(32)) b0 ();
  dmem_responder_if #(.ADDR_W(32)) b1 ();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0), .ADDR_W(32)) dut0 (
    .clock(clock), .reset(reset), .bus(b0.slave));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1), .ADDR_W(32)) dut1 (
    .clock(clock), .reset(reset), .bus(b1.slave));

  assign b0.req_valid  = t_req_valid & ~sel;
  assign b1.req_valid  = t_req_valid & sel;
  assign b0.resp_ready = t_resp_ready & ~sel;
  assign b1.resp_ready = t_resp_ready & sel;
  assign b0.req_write  = t_req_write;
  assign b1.req_write  = t_req_write;
  assign b0.req_funct3 = t_f3;
  assign b1.req_funct3 = t_f3;
  assign b0.req_addr   = t_addr;
  assign b1.req_addr   = t_addr;
  assign b0.req_wdata  = t_wdata;
  assign b1.req_wdata  = t_wdata;

  assign o_req_ready  = sel ? b1.req_ready  : b0.req_ready;
  assign o_resp_valid = sel ? b1.resp_valid : b0.resp_valid;
  assign o_resp_rdata = sel ? b1.resp_rdata : b0.resp_rdata;
  assign o_resp_err   = sel ? b1.resp_err   : b0.resp_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Reference: memory as plain words, accesses as shifts and masks.
  function automatic void ref_op(input logic s, input logic w, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] rd, output logic er);
    int unsigned idx, lane, nbytes, mask, v;
    logic [7:0] i8;
    bit legal;
    idx    = a >> 2;
    lane   = a & 3;
    nbytes = 1 << (f3 & 3);
    legal  = w ? (f3 <= 2) : (f3 != 3 && f3 != 6 && f3 != 7);
    er     = !legal || idx >= DEPTH || ((lane % nbytes) != 0);
    rd     = '0;
    if (er) return;
    i8   = 8'(idx);
    mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
    if (w) begin
      rmem[s][i8] = (rmem[s][i8] & ~(mask << (8 * lane))) | ((d & mask) << (8 * lane));
    end else begin
      v = (rmem[s][i8] >> (8 * lane)) & mask;
      if (f3 < 4 && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 1) == 1) v = v | ~mask;
      rd = v;
    end
  endfunction

  task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input int hold,
                     output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          lat, n, exp_lat;
    ref_op(sel, w, f3, a, d, exp_rd, exp_er);
    exp_lat = (sel ? LAT1 : LAT0) + 2;
    @(negedge clock);
    t_req_valid = 1'b1; t_req_write = w; t_f3 = f3; t_addr = a; t_wdata = d;
    t_resp_ready = 1'b0;
    n = 0;
    while (!o_req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk1("req_ready_idle", o_req_ready, 1'b1);
    @(posedge clock);
    #1;
    t_req_valid = 1'b0;
    t_req_write = 1'($urandom);
    t_f3        = 3'($urandom);
    t_addr      = $urandom;
    t_wdata     = $urandom;
    lat = 0;
    while (!o_resp_valid && lat < 40) begin
      chk1("req_ready_busy", o_req_ready, 1'b0);
      @(posedge clock);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    rd = o_resp_rdata;
    er = o_resp_err;
    chk("rdata", rd, exp_rd);
    chk1("err", er, exp_er);
    t_resp_ready = 1'($urandom);
    t_resp_ready = 1'b0;
    repeat (hold) begin
      @(posedge clock);
      #1;
      chk1("hold_valid", o_resp_valid, 1'b1);
      chk("hold_rdata", o_resp_rdata, rd);
      chk1("hold_err", o_resp_err, er);
      chk1("hold_req_ready", o_req_ready, 1'b0);
    end
    t_resp_ready = 1'b1;
    @(posedge clock);
    #1;
    t_resp_ready = 1'b0;
    chk1("valid_after_hs", o_resp_valid, 1'b0);
    chk1("ready_after_hs", o_req_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic        er, w;
    logic [2:0]  f3;
    int          hold;
    logic [7:0]  i8;

    sel = 1'b0; reset = 1'b1;
    t_req_valid = 1'b0; t_req_write = 1'b0; t_resp_ready = 1'b0;
    t_f3 = '0; t_addr = '0; t_wdata = '0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) rmem[s][i] = 0;

    #2 reset = 1'b0;
    #1;
    chk1("rst_req_ready", o_req_ready, 1'b1);
    chk1("rst_resp_valid", o_resp_valid, 1'b0);
    chk("rst_rdata", o_resp_rdata, 32'h0);
    chk1("rst_err", o_resp_err, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) txn(1'b1, 3'd2, 32'(i * 4), $urandom, 0, rd, er);

    txn(1'b1, 3'd2, 32'd0, 32'd5, 0, rd, er);
    txn(1'b0, 3'd2, 32'd0, 32'd0, 0, rd, er);
    chk("plan_lw0", rd, 32'd5);
    chk1("plan_lw0_err", er, 1'b0);

    txn(1'b1, 3'd2, 32'd4, 32'd10, 0, rd, er);
    chk("plan_dmem1", dut0.DMem[8'd1], 32'd10);
    txn(1'b0, 3'd2, 32'd4, 32'd0, 1, rd, er);
    chk("plan_lw4", rd, 32'd10);
    txn(1'b1, 3'd2, 32'd8, 32'd1234, 0, rd, er);
    chk("plan_dmem2", dut0.DMem[8'd2], 32'd1234);

    txn(1'b1, 3'd2, 32'd8, 32'h1122_3344, 0, rd, er);
    txn(1'b1, 3'd0, 32'd9, 32'h0000_0080, 0, rd, er);
    chk("plan_sb", dut0.DMem[8'd2], 32'h1122_8044);
    txn(1'b0, 3'd0, 32'd9, 32'd0, 0, rd, er);
    chk("plan_lb", rd, 32'hFFFF_FF80);
    txn(1'b0, 3'd4, 32'd9, 32'd0, 0, rd, er);
    chk("plan_lbu", rd, 32'h0000_0080);
    txn(1'b0, 3'd1, 32'd10, 32'd0, 0, rd, er);
    chk("plan_lh", rd, 32'h0000_1122);

    txn(1'b0, 3'd2, 32'd6, 32'd0, 0, rd, er);
    chk1("err_lw6", er, 1'b1);
    chk("err_lw6_rdata", rd, 32'h0);
    txn(1'b1, 3'd1, 32'd3, 32'h0000_BEEF, 0, rd, er);
    chk1("err_sh3", er, 1'b1);
    chk("err_sh3_rdata", rd, 32'h0);
    txn(1'b0, 3'd2, 32'(4 * DEPTH), 32'd0, 0, rd, er);
    chk1("err_range", er, 1'b1);
    chk("err_range_rdata", rd, 32'h0);
    txn(1'b0, 3'd3, 32'd0, 32'd0, 0, rd, er);
    chk1("err_f3", er, 1'b1);
    chk("err_f3_rdata", rd, 32'h0);
    chk("err_dmem0", dut0.DMem[8'd0], 32'd5);
    chk("err_dmem1", dut0.DMem[8'd1], 32'd10);
    chk("err_dmem2", dut0.DMem[8'd2], 32'h1122_8044);

    txn(1'b0, 3'd2, 32'd0, 32'd0, 5, rd, er);
    chk("hold5_rdata", rd, 32'd5);

    for (int k = 0; k < 200; k++) begin
      w    = 1'($urandom);
      f3   = 3'($urandom);
      a    = $urandom_range(0, 4 * DEPTH + 15);
      d    = $urandom;
      hold = $urandom_range(0, 2);
      txn(w, f3, a, d, hold, rd, er);
      if (w && !er) begin
        i8 = a[9:2];
        chk("rand_dmem", dut0.DMem[i8], rmem[0][i8]);
      end
    end

    @(negedge clock);
    t_req_valid = 1'b1; t_req_write = 1'b1; t_f3 = 3'd2; t_addr = 32'd12; t_wdata = 32'd99;
    chk1("abort_accept_ready", o_req_ready, 1'b1);
    @(posedge clock);
    #1 t_req_valid = 1'b0;
    @(posedge clock);
    #1;
    chk1("abort_in_wait", o_req_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk1("abort_async_ready", o_req_ready, 1'b1);
    chk1("abort_async_valid", o_resp_valid, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    repeat (8) begin
      @(posedge clock);
      #1;
      chk1("abort_no_resp", o_resp_valid, 1'b0);
    end
    chk1("abort_ready_after", o_req_ready, 1'b1);
    chk("abort_dmem3", dut0.DMem[8'd3], rmem[0][3]);

    sel = 1'b1;
    txn(1'b1, 3'd2, 32'd0, 32'd7, 0, rd, er);
    chk("lat0_dmem0", dut1.DMem[8'd0], 32'd7);
    txn(1'b0, 3'd2, 32'd0, 32'd0, 2, rd, er);
    chk("lat0_lw0", rd, 32'd7);
    chk1("lat0_err", er, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
